// File: rtl/mem_stage_stall.sv
// Memory stage with multi-cycle word array access, stall/done handshake and
// rejection of misaligned or read+write requests. Freezes permanently on halt.
module mem_stage_stall #(
  parameter int unsigned DATA_W     = 16,
  parameter int unsigned ADDR_W     = 16,
  parameter int unsigned DEPTH_LOG2 = 8,
  parameter int unsigned LATENCY    = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              memRead,
  input  logic              memWrite,
  input  logic [ADDR_W-1:0] aluOut,
  input  logic [DATA_W-1:0] writeData,
  input  logic              halt,
  output logic [DATA_W-1:0] readData,
  output logic              stall,
  output logic              done,
  output logic              err
);

  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
  localparam int unsigned CNT_W = $clog2(LATENCY + 1);

  typedef enum logic [1:0] {IDLE, BUSY, DONE, HALTED} state_t;

  state_t                  state, state_n;
  logic [CNT_W-1:0]        cnt, cnt_n;
  logic                    op_wr, op_wr_n;
  logic [DEPTH_LOG2-1:0]   idx, idx_n;
  logic [DATA_W-1:0]       wdata, wdata_n;
  logic [DATA_W-1:0]       rdata_n;
  logic                    done_n, err_n;
  logic                    mem_we;
  logic                    req, bad;
  logic [DATA_W-1:0]       mem [DEPTH];

  // Address bits above the word index only alias the array.
  logic unused_addr_hi;
  assign unused_addr_hi = ^aluOut[ADDR_W-1:DEPTH_LOG2+1];

  assign req   = memRead | memWrite;
  assign bad   = aluOut[0] | (memRead & memWrite);
  assign stall = ((state == IDLE) & req & ~halt) | (state == BUSY);

  // Next-state and registered-output decode.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    op_wr_n = op_wr;
    idx_n   = idx;
    wdata_n = wdata;
    rdata_n = readData;
    done_n  = 1'b0;
    err_n   = 1'b0;
    mem_we  = 1'b0;
    case (state)
      IDLE: begin
        if (halt) begin
          state_n = HALTED;
        end else if (req && bad) begin
          state_n = DONE;
          done_n  = 1'b1;
          err_n   = 1'b1;
        end else if (req) begin
          state_n = BUSY;
          op_wr_n = memWrite;
          idx_n   = aluOut[DEPTH_LOG2:1];
          wdata_n = writeData;
          cnt_n   = CNT_W'(LATENCY - 1);
        end
      end
      BUSY: begin
        if (cnt != '0) begin
          cnt_n = cnt - CNT_W'(1);
        end else begin
          state_n = DONE;
          done_n  = 1'b1;
          if (op_wr) mem_we = 1'b1;
          else       rdata_n = mem[idx];
        end
      end
      DONE:    state_n = IDLE;
      HALTED:  state_n = HALTED;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      op_wr    <= 1'b0;
      idx      <= '0;
      wdata    <= '0;
      readData <= '0;
      done     <= 1'b0;
      err      <= 1'b0;
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      op_wr    <= op_wr_n;
      idx      <= idx_n;
      wdata    <= wdata_n;
      readData <= rdata_n;
      done     <= done_n;
      err      <= err_n;
    end
  end

  // Array is not reset; a reset landing on the final BUSY edge cancels the store.
  always_ff @(posedge clk) begin
    if (mem_we && !rst) mem[idx] <= wdata;
  end

endmodule

// File: tb/tb_mem_stage_stall.sv
// Bench for mem_stage_stall: three instances (LATENCY 2, 1, 5) checked against
// a transaction-level model of array contents and access timing.
module tb_mem_stage_stall;

  logic        clk = 1'b0;
  logic        rst_v [3];
  logic        mr [3];
  logic        mw [3];
  logic [15:0] ad [3];
  logic [15:0] wd [3];
  logic        hl [3];
  logic [15:0] rdd [3];
  logic        st [3];
  logic        dn [3];
  logic        er [3];

  int n_cmp = 0;
  int n_err = 0;

  logic [15:0] ref_mem [int];
  logic [15:0] rd_model [3];
  logic [15:0] waddr [$];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    mem_stage_stall #(
      .DATA_W(16), .ADDR_W(16), .DEPTH_LOG2(8),
      .LATENCY(g == 0 ? 2 : (g == 1 ? 1 : 5))
    ) u_dut (
      .clk(clk), .rst(rst_v[g]), .memRead(mr[g]), .memWrite(mw[g]),
      .aluOut(ad[g]), .writeData(wd[g]), .halt(hl[g]),
      .readData(rdd[g]), .stall(st[g]), .done(dn[g]), .err(er[g])
    );
  end

  function automatic int lat_of(input int k);
    return (k == 0) ? 2 : ((k == 1) ? 1 : 5);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic idle_inputs(input int k);
    mr[k] = 1'b0; mw[k] = 1'b0; ad[k] = '0; wd[k] = '0; hl[k] = 1'b0;
  endtask

  task automatic reset_dut(input int k);
    @(posedge clk); #1;
    rst_v[k] = 1'b1;
    idle_inputs(k);
    @(posedge clk); #1;
    rst_v[k] = 1'b0;
    rd_model[k] = '0;
  endtask

  // One full transaction; upstream holds the request while stalled, inputs
  // are scrambled once the request has been accepted.
  task automatic access(input int k, input bit r, input bit w,
                        input logic [15:0] a, input logic [15:0] d);
    bit          bad;
    int          c;
    int          key;
    logic [15:0] exp_rd;
    string       t;
    bad    = a[0] | (r & w);
    key    = k * 256 + int'(a[8:1]);
    exp_rd = rd_model[k];
    if (!bad && r && ref_mem.exists(key)) exp_rd = ref_mem[key];
    t = $sformatf("dut%0d %s@%h", k, r ? (w ? "rw" : "rd") : "wr", a);
    @(posedge clk); #1;
    mr[k] = r; mw[k] = w; ad[k] = a; wd[k] = d;
    @(negedge clk);
    chk({t, " stall_c0"}, 32'(st[k]), 32'd1);
    chk({t, " done_c0"}, 32'(dn[k]), 32'd0);
    c = 0;
    do begin
      @(posedge clk); #1;
      mr[k] = 1'($urandom); mw[k] = 1'($urandom);
      ad[k] = 16'($urandom); wd[k] = 16'($urandom);
      @(negedge clk);
      c++;
      if (!dn[k]) chk({t, " stall_busy"}, 32'(st[k]), 32'd1);
    end while (!dn[k] && c < 40);
    chk({t, " total_cycles"}, 32'(c + 1), bad ? 32'd2 : 32'(lat_of(k) + 2));
    chk({t, " stall_done"}, 32'(st[k]), 32'd0);
    chk({t, " err"}, 32'(er[k]), 32'(bad));
    chk({t, " readData"}, 32'(rdd[k]), 32'(exp_rd));
    if (!bad && w) ref_mem[key] = d;
    rd_model[k] = exp_rd;
    @(posedge clk); #1;
    idle_inputs(k);
    @(negedge clk);
    chk({t, " done_clr"}, 32'(dn[k]), 32'd0);
    chk({t, " err_clr"}, 32'(er[k]), 32'd0);
    chk({t, " stall_idle"}, 32'(st[k]), 32'd0);
  endtask

  initial begin
    logic [15:0] a;
    logic [15:0] wa;
    int          sel;

    for (int k = 0; k < 3; k++) begin
      rst_v[k] = 1'b1;
      idle_inputs(k);
    end
    repeat (2) @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) rst_v[k] = 1'b0;
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("dut%0d rst readData", k), 32'(rdd[k]), 32'd0);
      chk($sformatf("dut%0d rst stall", k), 32'(st[k]), 32'd0);
      chk($sformatf("dut%0d rst done", k), 32'(dn[k]), 32'd0);
      chk($sformatf("dut%0d rst err", k), 32'(er[k]), 32'd0);
      rd_model[k] = '0;
    end

    // Directed sequence on the LATENCY=2 instance.
    access(0, 1'b0, 1'b1, 16'h0010, 16'hBEEF);
    access(0, 1'b1, 1'b0, 16'h0010, 16'h0000);
    access(0, 1'b1, 1'b0, 16'h0011, 16'h0000);
    access(0, 1'b1, 1'b0, 16'h0010, 16'h0000);
    access(0, 1'b0, 1'b1, 16'h0020, 16'h7777);
    access(0, 1'b1, 1'b1, 16'h0020, 16'h9999);
    access(0, 1'b1, 1'b0, 16'h0020, 16'h0000);
    access(0, 1'b0, 1'b1, 16'h0202, 16'h1234);
    access(0, 1'b1, 1'b0, 16'h0002, 16'h0000);
    access(0, 1'b0, 1'b1, 16'h0030, 16'h5555);

    // Reset lands during the second BUSY cycle of a store to 0x0030.
    @(posedge clk); #1;
    mw[0] = 1'b1; ad[0] = 16'h0030; wd[0] = 16'hAAAA;
    @(posedge clk); #1;
    idle_inputs(0);
    @(posedge clk); #1;
    rst_v[0] = 1'b1;
    @(posedge clk); #1;
    rst_v[0] = 1'b0;
    rd_model[0] = '0;
    @(negedge clk);
    chk("dut0 busy_rst stall", 32'(st[0]), 32'd0);
    chk("dut0 busy_rst done", 32'(dn[0]), 32'd0);
    chk("dut0 busy_rst readData", 32'(rdd[0]), 32'd0);
    access(0, 1'b1, 1'b0, 16'h0030, 16'h0000);

    // Random traffic on every instance.
    for (int k = 0; k < 3; k++) begin
      waddr.delete();
      for (int i = 0; i < 30; i++) begin
        sel = int'($urandom_range(0, 9));
        if (sel == 0) begin
          a = 16'($urandom) | 16'h0001;
          access(k, 1'($urandom), 1'b1, a, 16'($urandom));
        end else if (sel == 1) begin
          a = 16'($urandom);
          access(k, 1'b1, 1'b1, a, 16'($urandom));
        end else if (sel >= 6 && waddr.size() > 0) begin
          wa = waddr[$urandom_range(0, waddr.size() - 1)];
          a = 16'($urandom);
          a[8:0] = {wa[8:1], 1'b0};
          access(k, 1'b1, 1'b0, a, 16'($urandom));
        end else begin
          wa = 16'($urandom) & 16'hFFFE;
          waddr.push_back(wa);
          access(k, 1'b0, 1'b1, wa, 16'($urandom));
        end
      end
    end

    // halt freezes the stage until reset.
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      hl[k] = 1'b1; mr[k] = 1'b1; ad[k] = 16'h0010;
      @(negedge clk);
      chk($sformatf("dut%0d halt stall_c0", k), 32'(st[k]), 32'd0);
      for (int i = 0; i < 20; i++) begin
        @(posedge clk); #1;
        hl[k] = 1'($urandom); mr[k] = 1'($urandom); mw[k] = 1'($urandom);
        ad[k] = 16'($urandom) & 16'hFFFE; wd[k] = 16'($urandom);
        @(negedge clk);
        chk($sformatf("dut%0d halted stall %0d", k, i), 32'(st[k]), 32'd0);
        chk($sformatf("dut%0d halted done %0d", k, i), 32'(dn[k]), 32'd0);
      end
      reset_dut(k);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
